// File: rtl/demux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | demux_pkg: shared constants, state type and helper for the demux   |
// | path and its upstream sequencer.              Revision: 1.0        |
// +--------------------------------------------------------------------+
package demux_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } seq_state_t;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [SEL_W-1:0] k);
    ch_onehot    = '0;
    ch_onehot[k] = 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_rr_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | demux_rr_sequencer_if: request/data/grant bundle between the       |
// | requesters, the sequencer and the demux.      Revision: 1.0        |
// +--------------------------------------------------------------------+
interface demux_rr_sequencer_if;
  import demux_pkg::*;

  logic [NUM_CH-1:0] req;
  logic              din;
  logic [SEL_W-1:0]  sel;
  logic              i;
  logic [NUM_CH-1:0] gnt;
  logic              busy;
  logic              done;

  modport master (
    output req,
    output din,
    input  sel,
    input  i,
    input  gnt,
    input  busy,
    input  done
  );

  modport slave (
    input  req,
    input  din,
    output sel,
    output i,
    output gnt,
    output busy,
    output done
  );

endinterface
`default_nettype wire

// File: rtl/rr_pick8.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_pick8: combinational rotate-priority picker, first set request  |
// | at or after ptr (mod 8).                      Revision: 1.0        |
// +--------------------------------------------------------------------+
module rr_pick8 import demux_pkg::*; (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              found,
  output logic [SEL_W-1:0]  idx
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest candidate back to ptr so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int n = NUM_CH - 1; n >= 0; n--) begin
      cand = ptr + SEL_W'(n);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/demux_rr_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | demux_rr_sequencer: round-robin dwell/gap sequencer driving the    |
// | 8-way demux select and data bit.              Revision: 1.0        |
// +--------------------------------------------------------------------+
module demux_rr_sequencer #(
  parameter int DWELL = 4,
  parameter int GAP   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  demux_rr_sequencer_if.slave  bus
);
  import demux_pkg::*;

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_GRANT   = GRANT;
  localparam logic [1:0] ST_GAP     = demux_pkg::GAP;
  localparam logic [4:0] DWELL_LAST = 5'(DWELL - 1);
  localparam logic [4:0] GAP_LAST   = 5'(GAP - 1);

  logic [1:0]        state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;

  logic              in_grant;
  logic              req_hold;
  logic              last_dwell;
  logic              grant_end;
  logic              repick;
  logic              pick_found;
  logic [SEL_W-1:0]  next_ptr;
  logic [SEL_W-1:0]  pick_ptr;
  logic [SEL_W-1:0]  pick_idx;

  assign in_grant   = (state_q == ST_GRANT);
  assign req_hold   = bus.req[sel_q];
  assign last_dwell = (cnt_q == DWELL_LAST);
  assign grant_end  = in_grant && (!req_hold || last_dwell);
  assign next_ptr   = sel_q + 3'd1;
  // A zero-gap handover must search from the pointer being written this cycle.
  assign pick_ptr   = in_grant ? next_ptr : ptr_q;

  rr_pick8 u_pick (
    .req   (bus.req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    repick  = 1'b0;
    case (state_q)
      ST_IDLE: repick = 1'b1;
      ST_GRANT: begin
        if (grant_end) begin
          ptr_d = next_ptr;
          gnt_d = '0;
          cnt_d = '0;
          if (GAP > 0) state_d = ST_GAP;
          else         repick  = 1'b1;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) repick = 1'b1;
        else                   cnt_d  = cnt_q + 5'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    // sel only moves here, so the demux select is frozen for the whole grant.
    if (repick) begin
      cnt_d = '0;
      if (pick_found) begin
        state_d = ST_GRANT;
        sel_d   = pick_idx;
        gnt_d   = ch_onehot(pick_idx);
      end else begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.sel  = sel_q;
  assign bus.gnt  = gnt_q;
  assign bus.busy = (state_q != ST_IDLE);
  assign bus.i    = bus.din & in_grant & req_hold;
  assign bus.done = in_grant & req_hold & last_dwell;

endmodule
`default_nettype wire

// File: tb/tb_demux_rr_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_demux_rr_sequencer: three parameterisations driven in lockstep  |
// | and checked against a behavioural model.      Revision: 1.0        |
// +--------------------------------------------------------------------+
module tb_demux_rr_sequencer;

  localparam int N_DUT    = 3;
  localparam int PH_IDLE  = 0;
  localparam int PH_GRANT = 1;
  localparam int PH_GAP   = 2;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       din;
  logic [7:0] rnd_req;

  int n_tests = 0;
  int n_fail  = 0;

  int dw [N_DUT];
  int gp [N_DUT];
  int m_phase [N_DUT];
  int m_chan [N_DUT];
  int m_age [N_DUT];
  int m_gap_left [N_DUT];
  int m_ptr [N_DUT];
  int m_sel [N_DUT];

  demux_rr_sequencer_if bus0 ();
  demux_rr_sequencer_if bus1 ();
  demux_rr_sequencer_if bus2 ();

  assign bus0.req = req;  assign bus0.din = din;
  assign bus1.req = req;  assign bus1.din = din;
  assign bus2.req = req;  assign bus2.din = din;

  demux_rr_sequencer #(.DWELL(4), .GAP(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  demux_rr_sequencer #(.DWELL(4), .GAP(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  demux_rr_sequencer #(.DWELL(1), .GAP(3)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  logic [7:0] o_gnt [N_DUT];
  logic [2:0] o_sel [N_DUT];
  logic       o_i [N_DUT];
  logic       o_busy [N_DUT];
  logic       o_done [N_DUT];

  assign o_gnt[0] = bus0.gnt;  assign o_sel[0] = bus0.sel;  assign o_i[0] = bus0.i;
  assign o_busy[0] = bus0.busy;  assign o_done[0] = bus0.done;
  assign o_gnt[1] = bus1.gnt;  assign o_sel[1] = bus1.sel;  assign o_i[1] = bus1.i;
  assign o_busy[1] = bus1.busy;  assign o_done[1] = bus1.done;
  assign o_gnt[2] = bus2.gnt;  assign o_sel[2] = bus2.sel;  assign o_i[2] = bus2.i;
  assign o_busy[2] = bus2.busy;  assign o_done[2] = bus2.done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int n, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < N_DUT; n++) begin
      m_phase[n] = PH_IDLE;  m_chan[n] = 0;  m_age[n] = 0;
      m_gap_left[n] = 0;     m_ptr[n] = 0;   m_sel[n] = 0;
    end
  endtask

  task automatic model_repick(input int n);
    int k;
    k = pick(req, m_ptr[n]);
    if (k < 0) begin
      m_phase[n] = PH_IDLE;
    end else begin
      m_phase[n] = PH_GRANT;  m_chan[n] = k;  m_sel[n] = k;  m_age[n] = 0;
    end
  endtask

  // One clock edge of the sequencing rules, using the inputs held across the edge.
  task automatic model_advance();
    for (int n = 0; n < N_DUT; n++) begin
      case (m_phase[n])
        PH_IDLE: model_repick(n);
        PH_GRANT: begin
          if (!req[m_chan[n]] || m_age[n] == dw[n] - 1) begin
            m_ptr[n] = (m_chan[n] + 1) % 8;
            if (gp[n] > 0) begin
              m_phase[n] = PH_GAP;  m_gap_left[n] = gp[n];
            end else begin
              model_repick(n);
            end
          end else begin
            m_age[n]++;
          end
        end
        default: begin
          m_gap_left[n]--;
          if (m_gap_left[n] == 0) model_repick(n);
        end
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] e_gnt;
    logic       held;
    for (int n = 0; n < N_DUT; n++) begin
      held  = (m_phase[n] == PH_GRANT) && req[m_chan[n]];
      e_gnt = (m_phase[n] == PH_GRANT) ? 8'(1 << m_chan[n]) : 8'h00;
      chk({tag, ".gnt"},  n, o_gnt[n], e_gnt);
      chk({tag, ".sel"},  n, 8'(o_sel[n]), 8'(m_sel[n]));
      chk({tag, ".i"},    n, 8'(o_i[n]), 8'(held && din));
      chk({tag, ".busy"}, n, 8'(o_busy[n]), 8'(m_phase[n] != PH_IDLE));
      chk({tag, ".done"}, n, 8'(o_done[n]), 8'(held && (m_age[n] == dw[n] - 1)));
    end
  endtask

  task automatic apply(input logic [7:0] r, input logic d, input string tag);
    req = r;
    din = d;
    #1;
    check_all(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic step(input logic [7:0] r, input logic d, input string tag);
    apply(r, d, tag);
    tick();
  endtask

  initial begin
    dw[0] = 4;  gp[0] = 1;
    dw[1] = 4;  gp[1] = 0;
    dw[2] = 1;  gp[2] = 3;
    reset = 1'b1;
    req   = 8'h00;
    din   = 1'b0;
    rnd_req = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int n = 0; n < N_DUT; n++) begin
      chk("por.gnt", n, o_gnt[n], 8'h00);
      chk("por.sel", n, 8'(o_sel[n]), 8'h00);
      chk("por.busy", n, 8'(o_busy[n]), 8'h00);
    end
    check_all("por");
    reset = 1'b0;

    for (int c = 0; c < 16; c++) step(8'h20, 1'(c), "single");
    for (int c = 0; c < 40; c++) step(8'hFF, 1'(c), "all");
    for (int c = 0; c < 8; c++)  step(8'h00, 1'b1, "flush");
    for (int c = 0; c < 30; c++) step(8'h81, 1'(c >> 1), "wrap");

    // Drop req[3] in the second cycle of a grant to channel 3.
    for (int c = 0; c < 8; c++) step(8'h00, 1'b0, "flush");
    step(8'h08, 1'b1, "abort_pre");
    step(8'h08, 1'b1, "abort_c1");
    apply(8'h10, 1'b1, "abort_c2");
    chk("abort.done", 0, 8'(o_done[0]), 8'h00);
    chk("abort.i", 0, 8'(o_i[0]), 8'h00);
    tick();
    apply(8'h18, 1'b1, "abort_gap");
    chk("abort.gnt_off", 0, o_gnt[0], 8'h00);
    tick();
    apply(8'h18, 1'b1, "abort_next");
    chk("abort.next_gnt", 0, o_gnt[0], 8'h10);
    tick();
    for (int c = 0; c < 6; c++) step(8'h18, 1'(c), "abort_post");

    // Asynchronous reset in the middle of a grant cycle.
    for (int c = 0; c < 8; c++) step(8'h00, 1'b0, "flush");
    step(8'h40, 1'b1, "rst_pre");
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    for (int n = 0; n < N_DUT; n++) begin
      chk("rst_mid.sel", n, 8'(o_sel[n]), 8'h00);
      chk("rst_mid.gnt", n, o_gnt[n], 8'h00);
      chk("rst_mid.i", n, 8'(o_i[n]), 8'h00);
      chk("rst_mid.busy", n, 8'(o_busy[n]), 8'h00);
      chk("rst_mid.done", n, 8'(o_done[n]), 8'h00);
    end
    check_all("rst_mid");
    req = 8'h00;
    @(posedge clk);
    #3;
    reset = 1'b0;
    tick();
    step(8'h04, 1'b0, "rst_rel");
    apply(8'h04, 1'b1, "rst_grant");
    for (int n = 0; n < N_DUT; n++) begin
      chk("rst_grant.sel", n, 8'(o_sel[n]), 8'h02);
      chk("rst_grant.gnt", n, o_gnt[n], 8'h04);
    end
    tick();

    for (int c = 0; c < 8; c++)  step(8'h00, 1'b0, "flush");
    for (int c = 0; c < 10; c++) step(8'h00, 1'(c), "idle_gate");

    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) rnd_req = 8'($urandom_range(0, 255));
      step(rnd_req, 1'($urandom_range(0, 1)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
